// File: rtl/fetch_pkg.sv
// Shared types and constants for the decoupled instruction-fetch front end.
// FETCH_XLEN sizes the queue entry and must track the XLEN of fetch_prefetch_queue.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int PC_INC     = 4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO shared by the instruction queue and the in-flight tag queue.
// Pop on empty and push on full are ignored; clear empties it without touching storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  entry_t        wdata,
  output entry_t        rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= bump(wptr);
      if (do_pop)  rptr <= bump(rptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !clear) begin
      mem[wptr] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Decoupled fetch stage: issues sequential imem requests under a credit limit, buffers
// returned instructions for Decode, and drops stale responses after a redirect.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
);

  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int QCW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   outst;
  logic [OW-1:0]   drop;
  logic            fire;
  logic            rsp_ok;
  logic [31:0]     credit_used;

  logic            q_push;
  logic            q_pop;
  fetch_entry_t    q_wdata;
  fetch_entry_t    q_head;
  logic [QCW-1:0]  q_count;
  logic            q_empty;
  logic            q_full;

  logic [XLEN-1:0] tag_head;
  logic [OW-1:0]   tag_count;
  logic            tag_empty;
  logic            tag_full;
  logic            unused_ok;

  // Queue slots already promised: buffered entries plus live (non-dropped) requests.
  assign credit_used = 32'(q_count) + 32'(outst) - 32'(drop);

  assign rsp_ok = imem_rsp_valid && (outst != '0);

  assign imem_req_valid = !reset && !redirect_valid
                       && (outst < OW'(MAX_OUTST))
                       && (credit_used < 32'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign fire           = imem_req_valid && imem_req_ready;

  assign instr_valid    = !q_empty;
  assign instr_data     = q_head.instr;
  assign instr_pc       = q_head.pc;
  assign instr_pc_plus4 = q_head.pc + XLEN'(PC_INC);

  assign unused_ok = ^{tag_count, tag_empty, tag_full, q_full, redirect_pc[1:0]};

  // A redirect suppresses both push and pop; the clear input empties the queue instead.
  always_comb begin
    q_push  = 1'b0;
    q_pop   = 1'b0;
    q_wdata = '{pc: tag_head, instr: imem_rsp_data};
    if (!redirect_valid) begin
      q_pop  = instr_valid && !stall;
      q_push = rsp_ok && (drop == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      outst    <= outst - OW'(rsp_ok);
      drop     <= outst - OW'(rsp_ok);
    end else begin
      if (fire) fetch_pc <= fetch_pc + XLEN'(PC_INC);
      outst <= outst + OW'(fire) - OW'(rsp_ok);
      if (rsp_ok && (drop != '0)) drop <= drop - OW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_instr_q (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .clear (redirect_valid),
    .wdata (q_wdata),
    .rdata (q_head),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  // In-order pcs of in-flight requests; never cleared so stale responses still pop their tag.
  fetch_fifo #(
    .DEPTH   (MAX_OUTST),
    .entry_t (logic [XLEN-1:0])
  ) u_tag_q (
    .clk   (clk),
    .reset (reset),
    .push  (fire),
    .pop   (rsp_ok),
    .clear (1'b0),
    .wdata (fetch_pc),
    .rdata (tag_head),
    .count (tag_count),
    .empty (tag_empty),
    .full  (tag_full)
  );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: in-order memory model with variable latency plus a
// queue-level reference model of issued, stale and buffered fetches.
module tb_fetch_prefetch_queue;

  localparam int          XLEN      = 32;
  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } flight_t;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int cycle  = 0;
  int lat    = 1;
  int last_due = -1;
  int first_fire = -1;
  int first_valid = -1;
  int fires104 = 0;

  mem_req_t    memq[$];
  flight_t     flight[$];
  logic [31:0] instq[$];
  logic [31:0] seen[$];
  logic [31:0] model_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int live_flights();
    int n = 0;
    foreach (flight[i]) if (!flight[i].stale) n++;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] seen_at(input int k);
    return (seen.size() > k) ? seen[k] : 32'hxxxx_xxxx;
  endfunction

  task automatic doReset();
    reset = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    stall = 1'b0;
    #1;
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
    checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr_data", instr_data, 32'd0);
    checkOutput("rst_instr_pc", instr_pc, 32'd0);
    checkOutput("rst_instr_pc_plus4", instr_pc_plus4, 32'd4);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle++;
    memq.delete();
    flight.delete();
    instq.delete();
    seen.delete();
    model_pc = RESET_PC;
    last_due = -1;
    first_fire = -1;
    first_valid = -1;
    fires104 = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance env and model.
  task automatic applyStimulus(input bit rdy, input bit stl, input bit redir,
                               input logic [31:0] rpc, input bit spur);
    bit      rsp_now;
    bit      exp_valid;
    bit      dut_fire;
    int      due;
    flight_t f;
    rsp_now = (memq.size() != 0) && (memq[0].due <= cycle);
    imem_req_ready = rdy;
    stall          = stl;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rsp_valid = rsp_now || spur;
    imem_rsp_data  = rsp_now ? mem_word(memq[0].addr) : 32'($urandom);
    #1;
    exp_valid = !redir && (flight.size() < MAX_OUTST) && (instq.size() + live_flights() < DEPTH);
    checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_valid));
    checkOutput("req_addr", imem_req_addr, model_pc);
    checkOutput("instr_valid", 32'(instr_valid), 32'(instq.size() != 0));
    if (instq.size() != 0) begin
      checkOutput("instr_pc", instr_pc, instq[0]);
      checkOutput("instr_data", instr_data, mem_word(instq[0]));
      checkOutput("instr_pc_plus4", instr_pc_plus4, instq[0] + 32'd4);
    end

    dut_fire = imem_req_valid && rdy;
    if (dut_fire && first_fire < 0) first_fire = cycle;
    if (instr_valid && first_valid < 0) first_valid = cycle;
    if (dut_fire && imem_req_addr == 32'h104) fires104++;
    if (instr_valid && !stl && !redir) seen.push_back(instr_pc);

    if (rsp_now) void'(memq.pop_front());
    if (dut_fire) begin
      due = (cycle + lat > last_due + 1) ? cycle + lat : last_due + 1;
      memq.push_back('{addr: imem_req_addr, due: due});
      last_due = due;
    end

    if (redir) begin
      if ((rsp_now || spur) && flight.size() != 0) void'(flight.pop_front());
      foreach (flight[i]) flight[i].stale = 1'b1;
      instq.delete();
      model_pc = {rpc[31:2], 2'b00};
    end else begin
      if (instq.size() != 0 && !stl) void'(instq.pop_front());
      if ((rsp_now || spur) && flight.size() != 0) begin
        f = flight.pop_front();
        if (!f.stale) instq.push_back(f.pc);
      end
      if (exp_valid && rdy) begin
        flight.push_back('{pc: model_pc, stale: 1'b0});
        model_pc = model_pc + 32'd4;
      end
    end

    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  initial begin
    int bad;
    @(negedge clk);

    $display("[TB] reset and 1-cycle streaming");
    doReset();
    lat = 1;
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("first_latency", 32'(first_valid - first_fire), 32'd2);
    checkOutput("stream_pc0", seen_at(0), 32'h100);
    checkOutput("stream_pc1", seen_at(1), 32'h104);
    checkOutput("stream_pc2", seen_at(2), 32'h108);

    $display("[TB] stall fills the queue");
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 0, 0, 0);
    checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("stall_instr_valid", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i + 1 < seen.size(); i++) if (seen[i+1] !== seen[i] + 32'd4) bad++;
    checkOutput("stall_no_gap_or_dup", 32'(bad), 32'd0);
    checkOutput("stall_pop_count", 32'(seen.size() >= 14), 32'd1);

    $display("[TB] spurious response and held request");
    doReset();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("spur_instr_valid", 32'(instr_valid), 32'd0);
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("held_addr", imem_req_addr, 32'h104);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("fires_104", 32'(fires104), 32'd1);

    $display("[TB] redirect with two requests outstanding");
    doReset();
    lat = 2;
    for (int k = 0; k < 10 && flight.size() < 2; k++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 32'h2000, 0);
    seen.delete();
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("redir_pc0", seen_at(0), 32'h2000);
    checkOutput("redir_pc1", seen_at(1), 32'h2004);

    $display("[TB] redirect with response and pop in the same cycle");
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      if (instq.size() != 0 && memq.size() != 0 && memq[0].due <= cycle) break;
      applyStimulus(1, 0, 0, 0, 0);
    end
    applyStimulus(1, 0, 1, 32'h3000, 0);
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    checkOutput("same_cycle_empty", 32'(instr_valid), 32'd0);
    checkOutput("same_cycle_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("same_cycle_req_addr", imem_req_addr, 32'h3000);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0);

    $display("[TB] reset mid-stream");
    lat = 2;
    for (int k = 0; k < 10 && flight.size() < 2; k++) applyStimulus(1, 0, 0, 0, 0);
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("restart_pc0", seen_at(0), RESET_PC);

    $display("[TB] address wrap and randomized traffic");
    lat = 1;
    applyStimulus(1, 0, 1, 32'hFFFF_FFFA, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) lat = int'($urandom_range(1, 3));
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                    $urandom_range(0, 19) == 0, 32'($urandom), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
